// File: rtl/return_address_stack_pkg.sv
// rtl/return_address_stack_pkg.sv - shared defaults, index type and stack-op encoding for the return address stack
package return_address_stack_pkg;

    // Default geometry of the return address stack and its checkpoint FIFO
    localparam int RAS_DEPTH_DEFAULT             = 8;
    localparam int MAX_INFLIGHT_BRANCHES_DEFAULT = 4;
    localparam int RAS_ADDR_W                    = 32;

    // Stack pointer type for the default depth; also the snapshot FIFO payload
    typedef logic [$clog2(RAS_DEPTH_DEFAULT)-1:0] ras_index_t;

    // Per-cycle stack operation decoded from push/pop
    typedef enum logic [1:0] {
        RAS_OP_NONE    = 2'b00,
        RAS_OP_PUSH    = 2'b01,
        RAS_OP_POP     = 2'b10,
        RAS_OP_REPLACE = 2'b11
    } ras_op_e;

    // Fold the push/pop pair into a single operation code
    function automatic ras_op_e ras_decode_op(input logic push, input logic pop);
        ras_op_e op;
        op = RAS_OP_NONE;
        if (push && pop) begin
            op = RAS_OP_REPLACE;
        end else if (push) begin
            op = RAS_OP_PUSH;
        end else if (pop) begin
            op = RAS_OP_POP;
        end
        return op;
    endfunction

endpackage

// File: rtl/return_address_stack_if.sv
// rtl/return_address_stack_if.sv - fetch-side control and prediction bundle for the return address stack
interface return_address_stack_if;
    import return_address_stack_pkg::*;

    logic                  push;
    logic                  pop;
    logic [RAS_ADDR_W-1:0] new_addr;
    logic                  branch_fetched;
    logic                  branch_retired;
    logic                  branch_flush;
    logic [RAS_ADDR_W-1:0] addr;
    logic                  snapshot_full;

    // Fetch / predictor side drives controls and consumes the prediction
    modport master (
        output push, pop, new_addr, branch_fetched, branch_retired, branch_flush,
        input  addr, snapshot_full
    );

    // Return address stack side
    modport slave (
        input  push, pop, new_addr, branch_fetched, branch_retired, branch_flush,
        output addr, snapshot_full
    );
endinterface

// File: rtl/return_address_stack_ras_snapshot_fifo.sv
// rtl/return_address_stack_ras_snapshot_fifo.sv - checkpoint FIFO of stack pointers with flush and pass-through push+pop
module ras_snapshot_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    import return_address_stack_pkg::*;

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q, rd_d;
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW:0]      count_q, count_d;
    logic             full_q, full_d;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign data_o  = mem_q[rd_q];
    assign full_o  = full_q;
    assign empty_o = empty;

    // A push into a full FIFO only lands when a pop frees the head in the same cycle.
    // A pop on an empty FIFO only happens alongside a push: the new entry passes straight through.
    assign do_push = push_i && (!full_q || pop_i);
    assign do_pop  = pop_i && (!empty || push_i);

    // Next pointers, occupancy and registered full flag
    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (flush_i) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                wr_d = wr_q + PW'(1);
            end
            if (do_pop) begin
                rd_d = rd_q + PW'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + (PW+1)'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - (PW+1)'(1);
            end
        end
        full_d = (count_d == (PW+1)'(DEPTH));
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    // Payload storage; contents need no reset because occupancy guards every read
    always_ff @(posedge clk) begin
        if (rst && !flush_i && do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/return_address_stack.sv
// rtl/return_address_stack.sv - speculative return address stack with per-branch pointer checkpoints (RAS_RESET_CONTENTS_EN clears entries on reset)
module return_address_stack
    import return_address_stack_pkg::*;
#(
    parameter int RAS_DEPTH             = RAS_DEPTH_DEFAULT,
    parameter int MAX_INFLIGHT_BRANCHES = MAX_INFLIGHT_BRANCHES_DEFAULT
) (
    input logic                   clk,
    input logic                   rst,
    return_address_stack_if.slave ras
);
    localparam int IW = $clog2(RAS_DEPTH);

    typedef logic [IW-1:0] idx_t;

    logic [RAS_ADDR_W-1:0] stack_q [RAS_DEPTH];
    idx_t                  idx_q, idx_d;
    idx_t                  wr_idx;
    logic                  wr_en;
    ras_op_e               op;

    idx_t                  snap_head;
    logic                  snap_full;
    logic                  snap_empty;

    assign op                = ras_decode_op(ras.push, ras.pop);
    assign ras.addr          = stack_q[idx_q];
    assign ras.snapshot_full = snap_full;

    // Pointer and stack write decode; flush wins over every other control
    always_comb begin
        idx_d  = idx_q;
        wr_idx = idx_q;
        wr_en  = 1'b0;
        if (ras.branch_flush) begin
            if (!snap_empty) begin
                idx_d = snap_head;
            end
        end else begin
            case (op)
                RAS_OP_PUSH: begin
                    idx_d  = idx_q + IW'(1);
                    wr_idx = idx_q + IW'(1);
                    wr_en  = 1'b1;
                end
                RAS_OP_POP: begin
                    idx_d = idx_q - IW'(1);
                end
                RAS_OP_REPLACE: begin
                    wr_en = 1'b1;
                end
                default: begin
                    idx_d = idx_q;
                end
            endcase
        end
    end

    // Stack pointer register
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

`ifdef RAS_RESET_CONTENTS_EN
    // Stack entries as resettable flops so a prediction before any call reads zero
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else if (wr_en) begin
            stack_q[wr_idx] <= ras.new_addr;
        end
    end
`else
    // Stack entries as unreset RAM; reset only suppresses the write
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            stack_q[wr_idx] <= ras.new_addr;
        end
    end
`endif

    // Checkpoints hold the pointer as it was before this cycle's push/pop
    ras_snapshot_fifo #(
        .DEPTH (MAX_INFLIGHT_BRANCHES),
        .WIDTH (IW)
    ) u_snapshot_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (ras.branch_fetched && !ras.branch_flush),
        .pop_i   (ras.branch_retired && !ras.branch_flush),
        .flush_i (ras.branch_flush),
        .data_i  (idx_q),
        .data_o  (snap_head),
        .full_o  (snap_full),
        .empty_o (snap_empty)
    );

    // Fetch must never checkpoint into a full FIFO unless a retire frees a slot
    assert property (@(posedge clk) disable iff (!rst)
        !(ras.branch_fetched && snap_full && !ras.branch_retired && !ras.branch_flush));

endmodule
